// File: rtl/bist_patgen_if.sv
// Pattern delivery bus for bist_patgen: valid/ready handshake carrying the
// stimulus word and its index within the run.
interface bist_patgen_if #(
  parameter int WIDTH = 4
) ();
  logic             pat_valid;
  logic [WIDTH-1:0] pat;
  logic [7:0]       pat_idx;
  logic             ready;

  modport master (output pat_valid, output pat, output pat_idx, input ready);
  modport slave  (input pat_valid, input pat, input pat_idx, output ready);
endinterface

// File: rtl/bist_patgen.sv
// BIST pattern source: maximal-length Fibonacci LFSR words over a valid/ready bus.
// Optional macro BIST_PATGEN_ZERO_EN adds the de Bruijn all-zero state.
module bist_patgen #(
  parameter int WIDTH    = 4,
  parameter int SEED     = 1,
  parameter int NUM_PATS = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_abort,
  output logic           o_busy,
  output logic           o_done,
  bist_patgen_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Feedback tap masks per width, bit n set means pat[n] feeds the XOR.
  localparam logic [7:0] TAPS =
    (WIDTH == 2) ? 8'h03 :
    (WIDTH == 3) ? 8'h06 :
    (WIDTH == 4) ? 8'h0C :
    (WIDTH == 5) ? 8'h14 :
    (WIDTH == 6) ? 8'h30 :
    (WIDTH == 7) ? 8'h60 : 8'hB8;

  localparam logic [7:0] LAST_IDX = 8'(NUM_PATS - 1);

`ifdef BIST_PATGEN_ZERO_EN
  localparam logic [WIDTH-1:0] SEED_EFF = WIDTH'(SEED);
`else
  localparam logic [WIDTH-1:0] SEED_EFF =
    (WIDTH'(SEED) == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : WIDTH'(SEED);
`endif

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] p);
    logic [7:0] ext;
    logic       fb;
    ext = 8'(p);
    fb  = ^(ext & TAPS);
`ifdef BIST_PATGEN_ZERO_EN
    fb  = fb ^ (p[WIDTH-2:0] == {(WIDTH-1){1'b0}});
`endif
    return {p[WIDTH-2:0], fb};
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] w_pat;
  logic [7:0]       r_pat_idx;
  logic [7:0]       w_pat_idx;
  logic             r_pat_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_xfer;

  assign w_xfer = r_pat_valid & bus.ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort wins over a simultaneous final transfer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_next_state = S_DONE;
        end else if (w_xfer && (r_pat_idx == LAST_IDX)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Pattern/index update for the next cycle
  always_comb begin
    w_pat     = r_pat;
    w_pat_idx = r_pat_idx;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_pat     = SEED_EFF;
          w_pat_idx = 8'd0;
        end else begin
          w_pat     = r_pat;
          w_pat_idx = r_pat_idx;
        end
      end
      S_RUN: begin
        if (!i_abort && w_xfer && (r_pat_idx != LAST_IDX)) begin
          w_pat     = lfsr_next(r_pat);
          w_pat_idx = r_pat_idx + 8'd1;
        end else begin
          w_pat     = r_pat;
          w_pat_idx = r_pat_idx;
        end
      end
      default: begin
        w_pat     = r_pat;
        w_pat_idx = r_pat_idx;
      end
    endcase
  end

  // Registered outputs, derived from the upcoming state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat       <= {WIDTH{1'b0}};
      r_pat_idx   <= 8'd0;
      r_pat_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pat       <= w_pat;
      r_pat_idx   <= w_pat_idx;
      r_pat_valid <= (w_next_state == S_RUN);
      r_busy      <= (w_next_state == S_RUN);
      r_done      <= (w_next_state == S_DONE);
    end
  end

  assign bus.pat_valid = r_pat_valid;
  assign bus.pat       = r_pat;
  assign bus.pat_idx   = r_pat_idx;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_bist_patgen.sv
// Self-checking bench for bist_patgen: directed runs with random backpressure
// and abort points, checked against an arithmetic W4 LFSR model.
module tb_bist_patgen;

`ifdef BIST_PATGEN_ZERO_EN
  localparam int NA = 16;
`else
  localparam int NA = 15;
`endif
  localparam int NB = 20;

  logic clk;
  logic rst_n;
  logic start_a, abort_a, busy_a, done_a;
  logic start_b, abort_b, busy_b, done_b;

  bist_patgen_if #(.WIDTH(4)) bus_a ();
  bist_patgen_if #(.WIDTH(4)) bus_b ();

  bist_patgen #(.WIDTH(4), .SEED(1), .NUM_PATS(NA)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_abort(abort_a),
    .o_busy(busy_a), .o_done(done_a), .bus(bus_a)
  );

  bist_patgen #(.WIDTH(4), .SEED(1), .NUM_PATS(NB)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(abort_b),
    .o_busy(busy_b), .o_done(done_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  bit          cur_sel;
  int          model [64];
  logic [3:0]  obs_q [$];

  logic       vld, busy, done;
  logic [3:0] pat;
  logic [7:0] idx;

  always_comb begin
    if (cur_sel) begin
      vld = bus_b.pat_valid; busy = busy_b; done = done_b; pat = bus_b.pat; idx = bus_b.pat_idx;
    end else begin
      vld = bus_a.pat_valid; busy = busy_a; done = done_a; pat = bus_a.pat; idx = bus_a.pat_idx;
    end
  end

  // Polynomial x^4 + x^3 + 1 expressed as integer arithmetic
  function automatic int model_next(input int p);
    int fb;
    fb = ((p / 8) + (p / 4)) % 2;
`ifdef BIST_PATGEN_ZERO_EN
    if ((p % 8) == 0) fb = 1 - fb;
`endif
    return ((p * 2) % 16) + fb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit st, input bit ab, input bit rdy);
    if (cur_sel) begin
      start_b = st; abort_b = ab; bus_b.ready = rdy;
      start_a = 1'b0; abort_a = 1'b0; bus_a.ready = 1'b0;
    end else begin
      start_a = st; abort_a = ab; bus_a.ready = rdy;
      start_b = 1'b0; abort_b = 1'b0; bus_b.ready = 1'b0;
    end
  endtask

  // mode: 0 ready always, 1 ready 1,0,0 repeating, 2 random ready
  task automatic do_run(input bit sel, input int npats, input int mode, input int abort_at,
                        input int rst_at, input bit hold_start, input string tag);
    int nx;
    int cyc;
    int ph;
    bit rdy;
    bit fin;
    nx = 0; ph = 0; fin = 1'b0; cyc = 0;
    obs_q.delete();
    cur_sel = sel;
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0);
    @(negedge clk); set_in(hold_start, 1'b0, 1'b0);
    chk({tag, "_first_valid"}, {31'd0, vld}, 32'd1);
    while (!fin && cyc < 200) begin
      if (vld) begin
        chk({tag, "_pat"}, {28'd0, pat}, model[nx]);
        chk({tag, "_idx"}, {24'd0, idx}, nx);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_no_done"}, {31'd0, done}, 32'd0);
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = (ph % 3 == 0);
        else rdy = 1'($urandom_range(0, 1));
        ph++;
        if (nx == abort_at) begin
          set_in(hold_start, 1'b1, 1'b1);
          @(negedge clk);
          chk({tag, "_abort_valid"}, {31'd0, vld}, 32'd0);
          chk({tag, "_abort_done"}, {31'd0, done}, 32'd1);
          chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
          chk({tag, "_abort_idx"}, {24'd0, idx}, abort_at);
          set_in(1'b0, 1'b0, 1'b0);
          @(negedge clk);
          chk({tag, "_abort_done_once"}, {31'd0, done}, 32'd0);
          fin = 1'b1;
        end else if (nx == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk({tag, "_rst_valid"}, {31'd0, vld}, 32'd0);
          chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
          chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
          chk({tag, "_rst_pat"}, {28'd0, pat}, 32'd0);
          chk({tag, "_rst_idx"}, {24'd0, idx}, 32'd0);
          set_in(1'b0, 1'b0, 1'b0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          chk({tag, "_rst_no_done"}, {31'd0, done}, 32'd0);
          chk({tag, "_rst_idle"}, {31'd0, vld}, 32'd0);
          fin = 1'b1;
        end else begin
          set_in(hold_start, 1'b0, rdy);
          if (rdy) begin
            obs_q.push_back(pat);
            nx++;
          end
        end
      end else begin
        chk({tag, "_xfer_count"}, nx, npats);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        set_in(hold_start, 1'b0, 1'b0);
        @(negedge clk);
        chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_no_restart"}, {31'd0, vld}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int basic [15];
    int ab_at;
    logic [15:0] seen;
    basic = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    n_chk = 0; n_fail = 0; cur_sel = 1'b0;
    model[0] = 1;
    for (int i = 1; i < 64; i++) model[i] = model_next(model[i-1]);

    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; bus_a.ready = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; bus_b.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid_a", {31'd0, bus_a.pat_valid}, 32'd0);
    chk("reset_busy_a", {31'd0, busy_a}, 32'd0);
    chk("reset_done_a", {31'd0, done_a}, 32'd0);
    chk("reset_pat_a", {28'd0, bus_a.pat}, 32'd0);
    chk("reset_idx_a", {24'd0, bus_a.pat_idx}, 32'd0);
    chk("reset_valid_b", {31'd0, bus_b.pat_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(1'b0, NA, 0, -1, -1, 1'b0, "basic");
    for (int i = 0; i < 15; i++) begin
      if (obs_q.size() > i) chk("basic_table", {28'd0, obs_q[i]}, basic[i]);
      else chk("basic_table_missing", i, 15);
    end
`ifdef BIST_PATGEN_ZERO_EN
    seen = 16'd0;
    foreach (obs_q[i]) seen[obs_q[i]] = 1'b1;
    chk("zero_distinct", $countones(seen), 16);
    if (obs_q.size() > 15) chk("zero_idx15", {28'd0, obs_q[15]}, 32'd0);
    else chk("zero_idx15_missing", obs_q.size(), 16);
`else
    seen = 16'd0;
`endif

    do_run(1'b0, NA, 1, -1, -1, 1'b0, "bp_toggle");
    chk("bp_toggle_count", obs_q.size(), NA);
    do_run(1'b0, NA, 2, -1, -1, 1'b0, "bp_random");

    do_run(1'b0, NA, 0, 5, -1, 1'b0, "abort5");
    chk("abort5_counted", obs_q.size(), 5);
    do_run(1'b0, NA, 0, -1, -1, 1'b0, "after_abort");

    ab_at = $urandom_range(1, 13);
    do_run(1'b0, NA, 2, ab_at, -1, 1'b0, "abort_rand");
    chk("abort_rand_counted", obs_q.size(), ab_at);

    do_run(1'b0, NA, 0, -1, 7, 1'b0, "rst7");
    do_run(1'b0, NA, 0, -1, -1, 1'b0, "after_rst");

    do_run(1'b0, NA, 0, -1, -1, 1'b1, "hold_start");

    do_run(1'b1, NB, 0, -1, -1, 1'b1, "wrap");
    if (obs_q.size() > 15) begin
      chk("wrap_idx15_model", {28'd0, obs_q[15]}, model[15]);
`ifndef BIST_PATGEN_ZERO_EN
      chk("wrap_idx15_seed", {28'd0, obs_q[15]}, 32'd1);
`endif
    end else begin
      chk("wrap_idx15_missing", obs_q.size(), NB);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
